// File: rtl/icg_enable_ctrl_pkg.sv
// Shared types and constants for the clock-gate enable controller.
// Optional gated-cycle statistics are enabled by defining ICG_ENABLE_CTRL_STATS_EN.
package icg_enable_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  localparam int GATED_CYC_W = 16;
  localparam int WAKE_W      = 4;

  function automatic bit params_legal(int idle_w, int idle_thresh, int wake_cyc);
    return (idle_thresh >= 1) && (idle_thresh <= (1 << idle_w) - 1) &&
           (wake_cyc >= 1) && (wake_cyc <= 15);
  endfunction

endpackage

// File: rtl/icg_enable_ctrl_if.sv
// Activity/request inputs and gate-enable/status outputs of icg_enable_ctrl.
interface icg_enable_ctrl_if #(
  parameter int IDLE_W = 4
);
  logic                                    BUSY;
  logic                                    REQ;
  logic                                    SE;
  logic                                    E;
  logic                                    ACK;
  logic                                    GATED;
  logic [IDLE_W-1:0]                       IDLE_CNT;
  logic [icg_enable_ctrl_pkg::GATED_CYC_W-1:0] GATED_CYC;

  modport master (output BUSY, REQ, SE,
                  input  E, ACK, GATED, IDLE_CNT, GATED_CYC);
  modport slave  (input  BUSY, REQ, SE,
                  output E, ACK, GATED, IDLE_CNT, GATED_CYC);
endinterface

// File: rtl/icg_idle_timer.sv
// Saturating up-counter with clear; tc flags the count THRESH-1.
module icg_idle_timer #(
  parameter int W      = 4,
  parameter int THRESH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         tc
);
  localparam logic [W-1:0] TC_VAL = W'(THRESH - 1);

  assign tc = (cnt == TC_VAL);

  // Holding at tc keeps the counter from ever wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cnt <= '0;
    else if (clr)        cnt <= '0;
    else if (inc && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/icg_enable_ctrl.sv
// Registered enable generator for a negative-polarity ICG: idle gating, wake settle, REQ/ACK.
// Define ICG_ENABLE_CTRL_STATS_EN to count gated cycles on GATED_CYC.
module icg_enable_ctrl
  import icg_enable_ctrl_pkg::*;
#(
  parameter int IDLE_W      = 4,
  parameter int IDLE_THRESH = 8,
  parameter int WAKE_CYC    = 2
) (
  input  logic               CLK,
  input  logic               RST,
  icg_enable_ctrl_if.slave   bus
);
  if (!params_legal(IDLE_W, IDLE_THRESH, WAKE_CYC)) begin : g_bad_params
    $error("icg_enable_ctrl: IDLE_THRESH/WAKE_CYC out of range");
  end

  state_e            state_q, state_d;
  logic              e_q, gated_q, ack_q, ack_d, req_q;
  logic              idle_clr, idle_inc, idle_tc;
  logic              wake_clr, wake_inc, wake_tc;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WAKE_W-1:0] wake_cnt_unused;
  logic              idle, req_rise;

  assign idle     = !bus.BUSY && !bus.REQ;
  assign req_rise = bus.REQ && !req_q;

  icg_idle_timer #(.W(IDLE_W), .THRESH(IDLE_THRESH)) u_idle (
    .clk(CLK), .rst(RST), .clr(idle_clr), .inc(idle_inc), .cnt(idle_cnt), .tc(idle_tc)
  );

  icg_idle_timer #(.W(WAKE_W), .THRESH(WAKE_CYC)) u_wake (
    .clk(CLK), .rst(RST), .clr(wake_clr), .inc(wake_inc), .cnt(wake_cnt_unused), .tc(wake_tc)
  );

  always_comb begin
    state_d  = state_q;
    ack_d    = 1'b0;
    idle_clr = 1'b0;
    idle_inc = 1'b0;
    wake_clr = 1'b0;
    wake_inc = 1'b0;
    if (bus.SE) begin
      state_d  = ST_RUN;
      idle_clr = 1'b1;
      wake_clr = 1'b1;
      ack_d    = req_rise;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          ack_d = req_rise;
          if (!idle)        idle_clr = 1'b1;
          else if (idle_tc) begin
            state_d  = ST_GATED;
            idle_clr = 1'b1;
          end else          idle_inc = 1'b1;
        end
        ST_GATED: begin
          if (bus.BUSY || bus.REQ) begin
            state_d  = ST_WAKE;
            wake_clr = 1'b1;
          end
        end
        ST_WAKE: begin
          // Wake completes regardless of BUSY/REQ dropping meanwhile.
          if (wake_tc) begin
            state_d  = ST_RUN;
            idle_clr = 1'b1;
            wake_clr = 1'b1;
            ack_d    = bus.REQ;
          end else     wake_inc = 1'b1;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= ST_RUN;
      e_q     <= 1'b1;
      gated_q <= 1'b0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      e_q     <= (state_d != ST_GATED);
      gated_q <= (state_d == ST_GATED);
      ack_q   <= ack_d;
      req_q   <= bus.REQ;
    end
  end

  assign bus.E        = e_q;
  assign bus.GATED    = gated_q;
  assign bus.ACK      = ack_q;
  assign bus.IDLE_CNT = idle_cnt;

`ifdef ICG_ENABLE_CTRL_STATS_EN
  logic [GATED_CYC_W-1:0] gated_cyc_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              gated_cyc_q <= '0;
    else if (gated_q && gated_cyc_q != '1) gated_cyc_q <= gated_cyc_q + 1'b1;
  end
  assign bus.GATED_CYC = gated_cyc_q;
`else
  assign bus.GATED_CYC = '0;
`endif
endmodule

// File: tb/tb_icg_enable_ctrl.sv
// Directed bench for icg_enable_ctrl (IDLE_THRESH=8, WAKE_CYC=2).
module tb_icg_enable_ctrl;
  logic clk, rst;
  int   total = 0;
  int   bad   = 0;

  icg_enable_ctrl_if #(.IDLE_W(4)) bus ();

  icg_enable_ctrl #(.IDLE_W(4), .IDLE_THRESH(8), .WAKE_CYC(2)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gated();
    int n = 0;
    while (bus.GATED !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("wait_gated", {31'd0, bus.GATED}, 32'd1);
  endtask

  task automatic async_reset_release();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    bus.BUSY = 1'b0; bus.REQ = 1'b0; bus.SE = 1'b0;
    #3;
    chk("rst_E", {31'd0, bus.E}, 32'd1);
    chk("rst_ACK", {31'd0, bus.ACK}, 32'd0);
    chk("rst_GATED", {31'd0, bus.GATED}, 32'd0);
    chk("rst_IDLE_CNT", {28'd0, bus.IDLE_CNT}, 32'd0);
    chk("rst_GATED_CYC", {16'd0, bus.GATED_CYC}, 32'd0);
    async_reset_release();

    // Idle from reset: count 1..7, gate on edge 8
    for (int k = 1; k < 8; k++) begin
      step();
      chk("idle_cnt_seq", {28'd0, bus.IDLE_CNT}, k);
      chk("idle_E_high", {31'd0, bus.E}, 32'd1);
    end
    step();
    chk("gate_E", {31'd0, bus.E}, 32'd0);
    chk("gate_GATED", {31'd0, bus.GATED}, 32'd1);
    chk("gate_cnt_clr", {28'd0, bus.IDLE_CNT}, 32'd0);
    chk("gate_ACK", {31'd0, bus.ACK}, 32'd0);
`ifndef ICG_ENABLE_CTRL_STATS_EN
    step();
    chk("nostats_cyc0", {16'd0, bus.GATED_CYC}, 32'd0);
`endif

    // BUSY wakes without ACK
    bus.BUSY = 1'b1; step(); bus.BUSY = 1'b0;
    chk("busy_wake_E", {31'd0, bus.E}, 32'd1);
    chk("busy_wake_GATED", {31'd0, bus.GATED}, 32'd0);
    step(); step();
    chk("busy_wake_noack", {31'd0, bus.ACK}, 32'd0);
    chk("busy_wake_cnt", {28'd0, bus.IDLE_CNT}, 32'd0);

    // BUSY pulse at count 5 restarts the idle period
    repeat (5) step();
    chk("cnt5", {28'd0, bus.IDLE_CNT}, 32'd5);
    bus.BUSY = 1'b1; step(); bus.BUSY = 1'b0;
    chk("busy_clr", {28'd0, bus.IDLE_CNT}, 32'd0);
    repeat (7) step();
    chk("cnt7_again", {28'd0, bus.IDLE_CNT}, 32'd7);
    chk("not_gated_yet", {31'd0, bus.GATED}, 32'd0);
    // BUSY at terminal count wins
    bus.BUSY = 1'b1; step(); bus.BUSY = 1'b0;
    chk("tc_busy_cnt", {28'd0, bus.IDLE_CNT}, 32'd0);
    chk("tc_busy_nogate", {31'd0, bus.GATED}, 32'd0);
    repeat (7) step();
    chk("cnt7_third", {28'd0, bus.IDLE_CNT}, 32'd7);
    step();
    chk("gated_again", {31'd0, bus.GATED}, 32'd1);

    // REQ wake: E after 1 edge, ACK at edge 3, single pulse
    bus.REQ = 1'b1; step();
    chk("req_E_edge1", {31'd0, bus.E}, 32'd1);
    chk("req_ack_edge1", {31'd0, bus.ACK}, 32'd0);
    step();
    chk("req_ack_edge2", {31'd0, bus.ACK}, 32'd0);
    step();
    chk("req_ack_edge3", {31'd0, bus.ACK}, 32'd1);
    chk("req_run_GATED", {31'd0, bus.GATED}, 32'd0);
    step();
    chk("req_ack_once", {31'd0, bus.ACK}, 32'd0);
    bus.REQ = 1'b0; step();
    chk("req_drop_noack", {31'd0, bus.ACK}, 32'd0);
    chk("req_drop_cnt", {28'd0, bus.IDLE_CNT}, 32'd1);

    // REQ rising in RUN: ACK next edge
    bus.REQ = 1'b1; step();
    chk("run_req_ack", {31'd0, bus.ACK}, 32'd1);
    chk("run_req_cnt", {28'd0, bus.IDLE_CNT}, 32'd0);
    step();
    chk("run_req_ack_off", {31'd0, bus.ACK}, 32'd0);
    bus.REQ = 1'b0;

    // SE pulls out of GATED and holds RUN
    wait_gated();
    bus.SE = 1'b1; step();
    chk("se_E", {31'd0, bus.E}, 32'd1);
    chk("se_GATED", {31'd0, bus.GATED}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      step();
      chk("se_hold_E", {31'd0, bus.E}, 32'd1);
    end
    chk("se_cnt", {28'd0, bus.IDLE_CNT}, 32'd0);
    bus.REQ = 1'b1; step();
    chk("se_req_ack", {31'd0, bus.ACK}, 32'd1);
    chk("se_req_run", {31'd0, bus.GATED}, 32'd0);
    step();
    chk("se_req_ack_off", {31'd0, bus.ACK}, 32'd0);
    bus.REQ = 1'b0; bus.SE = 1'b0;

    // Asynchronous reset mid-WAKE
    wait_gated();
    bus.BUSY = 1'b1; step(); bus.BUSY = 1'b0;
    chk("wake_E", {31'd0, bus.E}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_wake_E", {31'd0, bus.E}, 32'd1);
    chk("arst_wake_ACK", {31'd0, bus.ACK}, 32'd0);
    chk("arst_wake_GATED", {31'd0, bus.GATED}, 32'd0);
    chk("arst_wake_cnt", {28'd0, bus.IDLE_CNT}, 32'd0);
    async_reset_release();

    // Asynchronous reset while GATED
    wait_gated();
    #2 rst = 1'b1;
    #1;
    chk("arst_gated_E", {31'd0, bus.E}, 32'd1);
    chk("arst_gated_GATED", {31'd0, bus.GATED}, 32'd0);
    async_reset_release();

    // Asynchronous reset while ACK high
    repeat (3) step();
    chk("pre_ack_cnt", {28'd0, bus.IDLE_CNT}, 32'd3);
    bus.REQ = 1'b1; step();
    chk("ack_before_rst", {31'd0, bus.ACK}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ack", {31'd0, bus.ACK}, 32'd0);
    chk("arst_ack_cnt", {28'd0, bus.IDLE_CNT}, 32'd0);
    bus.REQ = 1'b0;
    async_reset_release();

`ifdef ICG_ENABLE_CTRL_STATS_EN
    wait_gated();
    repeat (70000) @(posedge clk);
    #1;
    chk("stats_sat", {16'd0, bus.GATED_CYC}, 32'h0000FFFF);
    repeat (5) step();
    chk("stats_hold", {16'd0, bus.GATED_CYC}, 32'h0000FFFF);
`else
    wait_gated();
    repeat (10) step();
    chk("nostats_cyc_end", {16'd0, bus.GATED_CYC}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
